// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment driver with frame-synchronous update,
// leading-zero blanking, invalid-digit dashes and a stale-measurement timeout.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned DEAD_CYCLES  = 16,
    parameter int unsigned STALE_FRAMES = 200,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       stale
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned CNT_W = $clog2(STALE_FRAMES + 2);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DEAD_END = DIV_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALE_FRAMES);
    localparam logic             INV      = (ACTIVE_LOW != 0);
    localparam logic [2:0]       AN_OFF   = {3{INV}};
    localparam logic [6:0]       SEG_OFF  = {7{INV}};
    localparam logic [6:0]       SEG_DASH = 7'h40;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [11:0]      shown_q, shown_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             stale_q, stale_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             wrap;
    logic             boundary;
    logic [3:0]       digit;
    logic             dead;
    logic             blank;
    logic [2:0]       an_act;
    logic [6:0]       seg_act;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            shown_q     <= '0;
            frame_cnt_q <= '0;
            stale_q     <= 1'b1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            shown_q     <= shown_d;
            frame_cnt_q <= frame_cnt_d;
            stale_q     <= stale_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    // Slot timer, pending capture and frame-boundary transfer / timeout.
    always_comb begin
        div_d       = div_q + DIV_W'(1);
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        shown_d     = shown_q;
        frame_cnt_d = frame_cnt_q;
        stale_d     = stale_q;

        wrap     = (div_q == DIV_LAST);
        boundary = wrap && (idx_q == 2'd2);

        if (wrap) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        if (upd) begin
            pend_d   = {bcd2, bcd1, bcd0};
            pend_v_d = 1'b1;
        end

        if (boundary) begin
            if (upd || pend_v_q) begin
                shown_d     = upd ? {bcd2, bcd1, bcd0} : pend_q;
                pend_v_d    = 1'b0;
                stale_d     = 1'b0;
                frame_cnt_d = '0;
            end else begin
                if (frame_cnt_q != CNT_MAX) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
                if ((STALE_FRAMES != 0) && (frame_cnt_d == CNT_MAX)) begin
                    stale_d = 1'b1;
                end
            end
        end
    end

    // Digit content for the current slot; registered into an/seg.
    always_comb begin
        case (idx_q)
            2'd1:    digit = shown_q[7:4];
            2'd2:    digit = shown_q[11:8];
            default: digit = shown_q[3:0];
        endcase

        dead  = (div_q < DEAD_END);
        blank = ((idx_q == 2'd2) && (shown_q[11:8] == 4'd0)) ||
                ((idx_q == 2'd1) && (shown_q[11:4] == 8'd0));

        an_act  = '0;
        seg_act = '0;
        if (!dead) begin
            if (stale_q || (digit > 4'd9)) begin
                an_act  = 3'b001 << idx_q;
                seg_act = SEG_DASH;
            end else if (!blank) begin
                an_act  = 3'b001 << idx_q;
                seg_act = seg_decode(digit);
            end
        end

        an_d  = an_act ^ AN_OFF;
        seg_d = seg_act ^ SEG_OFF;
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign stale = stale_q;

endmodule
